// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial pattern detector.
package seq_det_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    function automatic logic [31:0] clamp_len(input logic [31:0] len, input logic [31:0] max_len);
        logic [31:0] res;
        if (len > max_len) begin
            res = max_len;
        end else begin
            res = len;
        end
        return res;
    endfunction

    // A length-1 pattern can match on the very first bit, so it starts armed.
    function automatic state_t state_for_len(input logic [31:0] len);
        state_t st;
        if (len == 32'd0) begin
            st = ST_IDLE;
        end else if (len == 32'd1) begin
            st = ST_ARMED;
        end else begin
            st = ST_FILL;
        end
        return st;
    endfunction

endpackage

// File: rtl/seq_detector_param_window.sv
// Shift history, fill counter and masked pattern compare for the detector.
module seq_window
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               shift_i,
    input  logic               bit_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    output logic               hit_o,
    output logic               fill_full_o
);

    logic [MAX_LEN-2:0] history_q;
    logic [MAX_LEN-2:0] history_d;
    logic [LEN_W-1:0]   fill_q;
    logic [LEN_W-1:0]   fill_d;
    logic [MAX_LEN-1:0] window_s;
    logic [MAX_LEN-1:0] mask_s;
    logic               len_nz_s;

    assign len_nz_s = (len_i != {LEN_W{1'b0}});
    assign window_s = {history_q, bit_i};

    // Mask, compare and next-state of history/fill.
    always_comb begin
        mask_s = {MAX_LEN{1'b0}};
        for (int i = 0; i < MAX_LEN; i++) begin
            mask_s[i] = (i < int'(len_i));
        end
        hit_o = len_nz_s && (fill_q >= len_i - LEN_W'(1))
                && (((window_s ^ pattern_i) & mask_s) == {MAX_LEN{1'b0}});
        if (clr_i) begin
            history_d = {(MAX_LEN-1){1'b0}};
            fill_d    = {LEN_W{1'b0}};
        end else if (shift_i) begin
            history_d = window_s[MAX_LEN-2:0];
            if (len_nz_s && (fill_q < len_i - LEN_W'(1))) begin
                fill_d = fill_q + LEN_W'(1);
            end else begin
                fill_d = fill_q;
            end
        end else begin
            history_d = history_q;
            fill_d    = fill_q;
        end
        // Looks one edge ahead so the FSM can register the armed state in step.
        fill_full_o = len_nz_s && (fill_d >= len_i - LEN_W'(1));
    end

    // History and fill registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            history_q <= {(MAX_LEN-1){1'b0}};
            fill_q    <= {LEN_W{1'b0}};
        end else begin
            history_q <= history_d;
            fill_q    <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Programmable serial pattern detector: config registers, FSM, outputs, match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
    parameter int                 CNT_W       = 16,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(3'b101),
    parameter int                 DEF_LEN     = 3,
    parameter bit                 DEF_OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               data_valid,
    input  logic               data_in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               count_clr,
    output logic               seq_detected,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed
);

    localparam logic [31:0]      DEF_LEN_32 = clamp_len(32'(DEF_LEN), 32'(MAX_LEN));
    localparam logic [LEN_W-1:0] DEF_LEN_C  = DEF_LEN_32[LEN_W-1:0];
    localparam state_t           RST_STATE  = state_for_len(DEF_LEN_32);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [MAX_LEN-1:0] pattern_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    state_t             state_q;
    state_t             state_d;
    logic               det_q;
    logic               armed_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [31:0]        len_c32_s;
    logic [LEN_W-1:0]   len_c_s;
    logic               accept_s;
    logic               hit_s;
    logic               match_s;
    logic               fill_full_s;
    logic               restart_s;

    assign len_c32_s = clamp_len(32'(cfg_len), 32'(MAX_LEN));
    assign len_c_s   = len_c32_s[LEN_W-1:0];
    // A config load steals the beat presented in the same cycle.
    assign accept_s  = data_valid && !cfg_load;
    assign match_s   = accept_s && hit_s;
    assign restart_s = cfg_load || (match_s && !ovl_q);

    seq_window #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_window (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (restart_s),
        .shift_i     (accept_s),
        .bit_i       (data_in),
        .pattern_i   (pattern_q),
        .len_i       (len_q),
        .hit_o       (hit_s),
        .fill_full_o (fill_full_s)
    );

    // FSM next state and saturating counter next value.
    always_comb begin
        state_d = state_q;
        if (cfg_load) begin
            state_d = state_for_len(len_c32_s);
        end else begin
            case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_FILL:  state_d = (accept_s && fill_full_s) ? ST_ARMED : ST_FILL;
                ST_ARMED: begin
                    if (match_s && !ovl_q && (len_q != LEN_W'(1))) begin
                        state_d = ST_FILL;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                default:  state_d = state_for_len(32'(len_q));
            endcase
        end
        if (count_clr) begin
            count_d = match_s ? CNT_W'(1) : {CNT_W{1'b0}};
        end else if (match_s && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // State, registered outputs, config and counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= RST_STATE;
            armed_q   <= (RST_STATE == ST_ARMED);
            det_q     <= 1'b0;
            count_q   <= {CNT_W{1'b0}};
            pattern_q <= DEF_PATTERN;
            len_q     <= DEF_LEN_C;
            ovl_q     <= DEF_OVERLAP;
        end else begin
            state_q <= state_d;
            armed_q <= (state_d == ST_ARMED);
            det_q   <= match_s;
            count_q <= count_d;
            if (cfg_load) begin
                pattern_q <= cfg_pattern;
                len_q     <= len_c_s;
                ovl_q     <= cfg_overlap;
            end else begin
                pattern_q <= pattern_q;
                len_q     <= len_q;
                ovl_q     <= ovl_q;
            end
        end
    end

    assign seq_detected = det_q;
    assign armed        = armed_q;
    assign match_count  = count_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param (MAX_LEN=8, CNT_W=2).
module tb_seq_detector_param;

    logic       clk;
    logic       rst_n;
    logic       data_valid;
    logic       data_in;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       count_clr;
    logic       seq_detected;
    logic [1:0] match_count;
    logic       armed;

    int n_cmp = 0;
    int n_err = 0;

    seq_detector_param #(
        .MAX_LEN (8),
        .CNT_W   (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_valid   (data_valid),
        .data_in      (data_in),
        .cfg_load     (cfg_load),
        .cfg_pattern  (cfg_pattern),
        .cfg_len      (cfg_len),
        .cfg_overlap  (cfg_overlap),
        .count_clr    (count_clr),
        .seq_detected (seq_detected),
        .match_count  (match_count),
        .armed        (armed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic d, input logic exp_det, input string tag);
        data_valid = 1'b1;
        data_in    = d;
        tick();
        data_valid = 1'b0;
        data_in    = 1'b0;
        chk(tag, 32'(seq_detected), 32'(exp_det));
    endtask

    task automatic gap(input logic d, input string tag);
        data_valid = 1'b0;
        data_in    = d;
        tick();
        data_in    = 1'b0;
        chk(tag, 32'(seq_detected), 32'd0);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_overlap = ovl;
        tick();
        cfg_load    = 1'b0;
    endtask

    task automatic clear_count();
        count_clr = 1'b1;
        tick();
        count_clr = 1'b0;
        chk("count_clr", 32'(match_count), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; data_valid = 1'b0; data_in = 1'b0; cfg_load = 1'b0;
        cfg_pattern = 8'h00; cfg_len = 4'd0; cfg_overlap = 1'b0; count_clr = 1'b0;
        tick();
        tick();
        chk("rst_det", 32'(seq_detected), 32'd0);
        chk("rst_cnt", 32'(match_count), 32'd0);
        chk("rst_armed", 32'(armed), 32'd0);
        rst_n = 1'b1;

        // Default 101, overlapping: stream 10101
        beat(1'b1, 1'b0, "t1_b1");
        chk("t1_armed_b1", 32'(armed), 32'd0);
        beat(1'b0, 1'b0, "t1_b2");
        chk("t1_armed_b2", 32'(armed), 32'd1);
        beat(1'b1, 1'b1, "t1_b3");
        beat(1'b0, 1'b0, "t1_b4");
        beat(1'b1, 1'b1, "t1_b5");
        chk("t1_cnt", 32'(match_count), 32'd2);

        // 1101 non-overlapping: stream 1101101
        clear_count();
        load(8'b0000_1101, 4'd4, 1'b0);
        chk("t2_armed_load", 32'(armed), 32'd0);
        beat(1'b1, 1'b0, "t2_b1");
        beat(1'b1, 1'b0, "t2_b2");
        beat(1'b0, 1'b0, "t2_b3");
        beat(1'b1, 1'b1, "t2_b4");
        chk("t2_armed_b4", 32'(armed), 32'd0);
        beat(1'b1, 1'b0, "t2_b5");
        beat(1'b0, 1'b0, "t2_b6");
        beat(1'b1, 1'b0, "t2_b7");
        chk("t2_armed_b7", 32'(armed), 32'd1);
        chk("t2_cnt", 32'(match_count), 32'd1);

        // 1101 overlapping: stream 1101101
        clear_count();
        load(8'b0000_1101, 4'd4, 1'b1);
        beat(1'b1, 1'b0, "t3_b1");
        beat(1'b1, 1'b0, "t3_b2");
        beat(1'b0, 1'b0, "t3_b3");
        beat(1'b1, 1'b1, "t3_b4");
        beat(1'b1, 1'b0, "t3_b5");
        beat(1'b0, 1'b0, "t3_b6");
        beat(1'b1, 1'b1, "t3_b7");
        chk("t3_cnt", 32'(match_count), 32'd2);

        // 101 with invalid gaps carrying garbage
        clear_count();
        load(8'b0000_0101, 4'd3, 1'b1);
        beat(1'b1, 1'b0, "t4_b1");
        gap(1'b0, "t4_g1");
        beat(1'b0, 1'b0, "t4_b2");
        gap(1'b1, "t4_g2");
        gap(1'b1, "t4_g3");
        beat(1'b1, 1'b1, "t4_b3");
        gap(1'b1, "t4_g4");
        chk("t4_cnt", 32'(match_count), 32'd1);

        // Length 0 disables detection
        load(8'b0000_0101, 4'd0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            beat(((i % 2) == 0) ? 1'b1 : 1'b0, 1'b0, "t5_len0");
        end
        chk("t5_armed", 32'(armed), 32'd0);
        chk("t5_cnt", 32'(match_count), 32'd1);

        // Length 15 clamps to 8: pattern A5
        load(8'hA5, 4'd15, 1'b1);
        beat(1'b1, 1'b0, "t6_b1");
        beat(1'b0, 1'b0, "t6_b2");
        beat(1'b1, 1'b0, "t6_b3");
        beat(1'b0, 1'b0, "t6_b4");
        beat(1'b0, 1'b0, "t6_b5");
        beat(1'b1, 1'b0, "t6_b6");
        chk("t6_armed_b6", 32'(armed), 32'd0);
        beat(1'b0, 1'b0, "t6_b7");
        chk("t6_armed_b7", 32'(armed), 32'd1);
        beat(1'b1, 1'b1, "t6_b8");
        chk("t6_cnt", 32'(match_count), 32'd2);

        // Saturation with a length-1 pattern
        clear_count();
        load(8'b0000_0001, 4'd1, 1'b1);
        chk("t7_armed_load", 32'(armed), 32'd1);
        beat(1'b1, 1'b1, "t7_m1");
        chk("t7_cnt1", 32'(match_count), 32'd1);
        beat(1'b1, 1'b1, "t7_m2");
        chk("t7_cnt2", 32'(match_count), 32'd2);
        beat(1'b1, 1'b1, "t7_m3");
        chk("t7_cnt3", 32'(match_count), 32'd3);
        beat(1'b1, 1'b1, "t7_m4");
        beat(1'b1, 1'b1, "t7_m5");
        chk("t7_sat", 32'(match_count), 32'd3);
        count_clr = 1'b1;
        beat(1'b1, 1'b1, "t7_clr_det");
        count_clr = 1'b0;
        chk("t7_clr_match", 32'(match_count), 32'd1);

        // Load wins over a coincident valid beat
        data_valid = 1'b1;
        data_in    = 1'b1;
        load(8'b0000_0001, 4'd1, 1'b1);
        data_valid = 1'b0;
        data_in    = 1'b0;
        chk("t7_load_det", 32'(seq_detected), 32'd0);
        chk("t7_load_cnt", 32'(match_count), 32'd1);

        // Reset mid-pattern, with a would-be completing bit during reset
        load(8'b0000_0101, 4'd3, 1'b1);
        beat(1'b1, 1'b0, "t8_b1");
        beat(1'b0, 1'b0, "t8_b2");
        rst_n      = 1'b0;
        data_valid = 1'b1;
        data_in    = 1'b1;
        tick();
        rst_n      = 1'b1;
        data_valid = 1'b0;
        data_in    = 1'b0;
        chk("t8_rst_det", 32'(seq_detected), 32'd0);
        chk("t8_rst_cnt", 32'(match_count), 32'd0);
        chk("t8_rst_armed", 32'(armed), 32'd0);
        beat(1'b1, 1'b0, "t8_after1");
        beat(1'b0, 1'b0, "t8_after2");
        beat(1'b1, 1'b1, "t8_after3");
        chk("t8_cnt", 32'(match_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised successor to the fixed "101" sequence detector.
- Detects a run-time programmable serial bit pattern of length 1..MAX_LEN on a qualified bit stream.
- Supports overlapping and non-overlapping detection, and keeps a saturating match counter.
- Sits on a serial calibration/ranging bit stream, e.g. sync-word or preamble detection ahead of DDS control.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (2..32).
- LEN_W, $clog2(MAX_LEN+1), width of length fields (derived; not overridden).
- CNT_W, 16, width of match counter.
- DEF_PATTERN, 'b101, pattern loaded at reset (LSB-aligned).
- DEF_LEN, 3, pattern length loaded at reset.
- DEF_OVERLAP, 1, overlap mode loaded at reset (1 = overlapping).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- data_valid  in  1  data_in qualifier; only valid beats advance the detector.
- data_in  in  1  serial data bit.
- cfg_load  in  1  one-cycle strobe: latch cfg_pattern/cfg_len/cfg_overlap and clear history.
- cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is first-received, bit 0 is last-received.
- cfg_len  in  LEN_W  pattern length.
- cfg_overlap  in  1  1 = overlapping, 0 = non-overlapping.
- count_clr  in  1  synchronous clear of match_count.
- seq_detected  out  1  registered one-cycle pulse per match.
- match_count  out  CNT_W  saturating number of matches.
- armed  out  1  registered; high when the next valid bit can complete a match.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pattern_q=DEF_PATTERN, len_q=DEF_LEN, ovl_q=DEF_OVERLAP.
  - history=0, fill=0, state=FILL (IDLE if DEF_LEN==0).
  - seq_detected=0, match_count=0, armed=0 (armed=1 only if DEF_LEN==1).
- Config latch on cfg_load:
  - cfg_len is clamped: 0 -> len_q=0 (detection disabled); >MAX_LEN -> len_q=MAX_LEN.
  - history and fill are cleared. data_valid in the same cycle is ignored.
  - match_count is not affected.
- History: on each accepted beat, history <= {history[MAX_LEN-2:0], data_in}.
- Match condition, evaluated on an accepted beat:
  - fill >= len_q-1, and
  - the low len_q bits of {history, data_in} equal pattern_q[len_q-1:0].
  - Bits of pattern_q above len_q-1 are ignored.
- State machine (state register, 2 bits):
  - IDLE: len_q==0. No matches, fill held at 0. Go to FILL on cfg_load with nonzero len.
  - FILL: fill < len_q-1. Each valid beat fill++. Go to ARMED when fill reaches len_q-1.
  - ARMED: the next valid beat may match.
    - Overlapping: stay in ARMED.
    - Non-overlapping, on match: fill=0, history=0, go to FILL (or stay ARMED if len_q==1).
    - No match: stay in ARMED.
  - Any state: cfg_load forces FILL/IDLE per the new length. rst_n forces reset values.
- fill saturates at len_q-1; it never wraps.
- Output timing:
  - seq_detected is high in the cycle after the clock edge that accepts the completing bit (latency 1). Low otherwise, including with data_valid=0.
  - armed is registered and reflects state==ARMED.
- Counter:
  - match_count increments on each match and saturates at 2^CNT_W-1.
  - count_clr together with a match gives match_count=1. count_clr alone gives 0.
- Simultaneous cfg_load and a valid beat: the load wins. The beat is dropped and no match is generated.
- Reset mid-pattern discards partial history. A match in the same cycle as reset is suppressed.

Decomposition:
- Package seq_det_pkg: state enum (ST_IDLE, ST_FILL, ST_ARMED), and the clamp function for cfg_len.
- One sub-module, seq_window: shift history, fill counter, masked compare. Outputs a combinational hit and fill_full.
- The top level holds config registers, the FSM, output registers and the counter.

Test Plan:
- Reset defaults, stream 1,0,1,0,1 all valid -> seq_detected pulses one cycle after the 3rd and 5th bits (overlap). match_count=2.
- cfg_load pattern 'b1101, len 4, overlap=0; stream 1101101 -> one pulse after bit 4 only, because bits 5-7 restart at fill=0 and "101" is incomplete. match_count=1.
- Same pattern with overlap=1, stream 1101101 -> pulses after bits 4 and 7. match_count=2.
- Default config, stream 1,0,1 with data_valid=0 gaps (and garbage data_in) between beats -> exactly one pulse, after the last valid beat. Gaps produce no pulses.
- cfg_len=0 -> no pulses for 20 bits of alternating 1/0, armed=0. cfg_len=15 with MAX_LEN=8 -> behaves as len 8: pattern 'hA5 with stream A5 -> one pulse.
- CNT_W=2: 5 matches -> match_count saturates at 3. count_clr coincident with a match -> 1. rst_n low mid-pattern after "10", then "1" -> no pulse.
